// File: rtl/quad_pkg.sv
// Shared encodings and helpers for the quadrature decoder: direction codes,
// forward Gray sequence, transition classification and symmetric saturation.
package quad_pkg;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Forward order of {A,B}: S0 -> S1 -> S2 -> S3 -> S0
    localparam logic [1:0] GRAY_S0 = 2'b00;
    localparam logic [1:0] GRAY_S1 = 2'b01;
    localparam logic [1:0] GRAY_S2 = 2'b11;
    localparam logic [1:0] GRAY_S3 = 2'b10;

    typedef enum logic [1:0] {
        MOVE_NONE    = 2'd0,
        MOVE_FWD     = 2'd1,
        MOVE_REV     = 2'd2,
        MOVE_ILLEGAL = 2'd3
    } move_e;

    function automatic logic [1:0] gray_fwd_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            GRAY_S0: nxt = GRAY_S1;
            GRAY_S1: nxt = GRAY_S2;
            GRAY_S2: nxt = GRAY_S3;
            default: nxt = GRAY_S0;
        endcase
        return nxt;
    endfunction

    function automatic move_e decode_move(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        move_e mv;
        if (cur_ab == prev_ab)                     mv = MOVE_NONE;
        else if (cur_ab == gray_fwd_next(prev_ab)) mv = MOVE_FWD;
        else if (prev_ab == gray_fwd_next(cur_ab)) mv = MOVE_REV;
        else                                       mv = MOVE_ILLEGAL;
        return mv;
    endfunction

    // Clamp to +/-(2^(w-1)-1); the most negative code is never produced.
    function automatic logic signed [63:0] sat_sym(input logic signed [63:0] v, input int w);
        logic signed [63:0] lim;
        logic signed [63:0] res;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        res = v;
        if (v > lim)  res = lim;
        if (v < -lim) res = -lim;
        return res;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder pin: 2-FF synchronizer followed by a stability filter that only
// follows the synced value after FILTER_LEN consecutive disagreeing samples.
module quad_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) filt_d = sync2_q;
            else                                cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/quad_encoder_decoder.sv
// x4 quadrature decoder with position count, windowed velocity and sticky error.
// Define QUAD_INDEX_EN to enable index-pin capture and index-driven position clear.
module quad_encoder_decoder
    import quad_pkg::*;
#(
    parameter int POS_WIDTH  = 32,
    parameter int VEL_WIDTH  = 16,
    parameter int FILTER_LEN = 4,
    parameter int VEL_WINDOW = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_i,
    input  logic                 index_clr_en,
    input  logic                 pos_clear,
    input  logic                 err_clear,
    output logic [POS_WIDTH-1:0] position,
    output logic                 step,
    output logic                 dir,
    output logic [VEL_WIDTH-1:0] velocity,
    output logic                 vel_valid,
    output logic                 err,
    output logic                 index_seen,
    output logic [POS_WIDTH-1:0] index_pos
);

    localparam int ARM_CNT = FILTER_LEN + 2;
    localparam int ARM_W   = $clog2(ARM_CNT + 2);
    localparam int WIN_W   = $clog2(VEL_WINDOW);
    localparam int ACC_W   = $clog2(VEL_WINDOW + 1) + 1;

    logic filt_a, filt_b, filt_i;

    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (.clk(clk), .rst_n(rst_n), .din(enc_a), .dout(filt_a));
    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (.clk(clk), .rst_n(rst_n), .din(enc_b), .dout(filt_b));

`ifdef QUAD_INDEX_EN
    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (.clk(clk), .rst_n(rst_n), .din(enc_i), .dout(filt_i));
`else
    logic unused_enc_i;
    assign unused_enc_i = enc_i;
    assign filt_i       = 1'b0;
`endif

    logic [ARM_W-1:0]            arm_cnt_q, arm_cnt_d;
    logic                        armed_q, armed_d;
    logic [1:0]                  ab_prev_q, ab_prev_d;
    logic                        idx_prev_q, idx_prev_d;
    logic [POS_WIDTH-1:0]        position_q, position_d;
    logic                        step_q, step_d;
    logic                        dir_q, dir_d;
    logic                        err_q, err_d;
    logic                        index_seen_q, index_seen_d;
    logic [POS_WIDTH-1:0]        index_pos_q, index_pos_d;
    logic [WIN_W-1:0]            win_cnt_q, win_cnt_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic [VEL_WIDTH-1:0]        velocity_q, velocity_d;
    logic                        vel_valid_q, vel_valid_d;

    move_e                       move;
    logic                        fwd, rev, index_rise, win_last;
    logic [POS_WIDTH-1:0]        pos_step;
    logic signed [ACC_W-1:0]     acc_step;
    logic signed [63:0]          acc_wide;

    always_comb begin
        arm_cnt_d    = armed_q ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
        armed_d      = armed_q | (arm_cnt_q == ARM_W'(ARM_CNT));
        ab_prev_d    = {filt_a, filt_b};
        idx_prev_d   = filt_i;

        move         = armed_q ? decode_move(ab_prev_q, {filt_a, filt_b}) : MOVE_NONE;
        fwd          = (move == MOVE_FWD);
        rev          = (move == MOVE_REV);
        index_rise   = armed_q & filt_i & ~idx_prev_q;

        pos_step     = position_q + (fwd ? POS_WIDTH'(1) : (rev ? {POS_WIDTH{1'b1}} : '0));
        step_d       = fwd | rev;
        dir_d        = fwd ? DIR_FWD : (rev ? DIR_REV : dir_q);
        err_d        = (move == MOVE_ILLEGAL) | (err_q & ~err_clear);

        // pos_clear outranks an index clear, which outranks the step itself
        position_d   = pos_step;
        index_seen_d = index_seen_q;
        index_pos_d  = index_pos_q;
        if (index_rise) begin
            index_seen_d = 1'b1;
            index_pos_d  = pos_step;
            if (index_clr_en) position_d = '0;
        end
        if (pos_clear) begin
            position_d   = '0;
            index_seen_d = 1'b0;
        end

        win_last     = (win_cnt_q == WIN_W'(VEL_WINDOW - 1));
        win_cnt_d    = win_last ? '0 : win_cnt_q + WIN_W'(1);
        acc_step     = acc_q + (fwd ? ACC_W'(1) : (rev ? {ACC_W{1'b1}} : '0));
        acc_wide     = 64'(acc_step);
        acc_d        = win_last ? '0 : acc_step;
        vel_valid_d  = win_last;
        velocity_d   = win_last ? VEL_WIDTH'(sat_sym(acc_wide, VEL_WIDTH)) : velocity_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arm_cnt_q    <= '0;
            armed_q      <= 1'b0;
            ab_prev_q    <= 2'b00;
            idx_prev_q   <= 1'b0;
            position_q   <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            err_q        <= 1'b0;
            index_seen_q <= 1'b0;
            index_pos_q  <= '0;
            win_cnt_q    <= '0;
            acc_q        <= '0;
            velocity_q   <= '0;
            vel_valid_q  <= 1'b0;
        end else begin
            arm_cnt_q    <= arm_cnt_d;
            armed_q      <= armed_d;
            ab_prev_q    <= ab_prev_d;
            idx_prev_q   <= idx_prev_d;
            position_q   <= position_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            err_q        <= err_d;
            index_seen_q <= index_seen_d;
            index_pos_q  <= index_pos_d;
            win_cnt_q    <= win_cnt_d;
            acc_q        <= acc_d;
            velocity_q   <= velocity_d;
            vel_valid_q  <= vel_valid_d;
        end
    end

    assign position   = position_q;
    assign step       = step_q;
    assign dir        = dir_q;
    assign err        = err_q;
    assign index_seen = index_seen_q;
    assign index_pos  = index_pos_q;
    assign velocity   = velocity_q;
    assign vel_valid  = vel_valid_q;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Bench for quad_encoder_decoder: directed scenarios plus random encoder motion,
// checked every cycle against a behavioural model; honours QUAD_INDEX_EN.
`timescale 1ns/1ps
module tb_quad_encoder_decoder;

    localparam int PW = 32;
    localparam int VW = 6;
    localparam int F  = 4;
    localparam int W  = 250;

    logic clk = 1'b0;
    logic rst_n = 1'b0, enc_a = 1'b0, enc_b = 1'b0, enc_i = 1'b0;
    logic index_clr_en = 1'b0, pos_clear = 1'b0, err_clear = 1'b0;
    logic [PW-1:0] position, index_pos;
    logic [VW-1:0] velocity;
    logic step, dir, vel_valid, err, index_seen;

    int checks = 0;
    int failures = 0;
    int step_cnt = 0;
    int g = 0;
    logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    always #5 clk = ~clk;

    quad_encoder_decoder #(.POS_WIDTH(PW), .VEL_WIDTH(VW), .FILTER_LEN(F), .VEL_WINDOW(W)) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i),
        .index_clr_en(index_clr_en), .pos_clear(pos_clear), .err_clear(err_clear),
        .position(position), .step(step), .dir(dir), .velocity(velocity),
        .vel_valid(vel_valid), .err(err), .index_seen(index_seen), .index_pos(index_pos)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_d1 [3], m_d2 [3], m_filt [3], m_fprev [3];
    logic [F-1:0]  m_hist [3];
    int            m_hi, m_acc;
    logic [PW-1:0] m_pos, m_ipos;
    logic [VW-1:0] m_vel;
    logic          m_step, m_dir, m_err, m_iseen, m_vv;

    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [VW-1:0] clampv(input int v);
        int lim;
        lim = (1 << (VW - 1)) - 1;
        if (v > lim)  v = lim;
        if (v < -lim) v = -lim;
        return VW'(v);
    endfunction

    always @(posedge clk) begin : model
        int   mv;
        logic ill, armed_use, irise;
        logic raw [3];
        raw[0] = enc_a; raw[1] = enc_b; raw[2] = enc_i;
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                m_d1[b] = 1'b0; m_d2[b] = 1'b0; m_filt[b] = 1'b0; m_fprev[b] = 1'b0; m_hist[b] = '0;
            end
            m_hi = 0; m_acc = 0; m_pos = '0; m_ipos = '0; m_vel = '0;
            m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0; m_iseen = 1'b0; m_vv = 1'b0;
        end else begin
            mv = 0; ill = 1'b0;
            armed_use = (m_hi >= F + 3);
            if (armed_use) begin
                case ((gpos({m_filt[0], m_filt[1]}) - gpos({m_fprev[0], m_fprev[1]}) + 4) % 4)
                    1: mv = 1;
                    2: ill = 1'b1;
                    3: mv = -1;
                    default: mv = 0;
                endcase
            end
`ifdef QUAD_INDEX_EN
            irise = armed_use && m_filt[2] && !m_fprev[2];
`else
            irise = 1'b0;
`endif
            m_step = (mv != 0);
            if (mv > 0) m_dir = 1'b1;
            else if (mv < 0) m_dir = 1'b0;
            m_err = ill || (m_err && !err_clear);
            if (irise) begin
                m_iseen = 1'b1;
                m_ipos  = m_pos + PW'(mv);
            end
            if (pos_clear) begin
                m_pos = '0;
                m_iseen = 1'b0;
            end else if (irise && index_clr_en) m_pos = '0;
            else m_pos = m_pos + PW'(mv);
            m_vv = 1'b0;
            if ((m_hi + 1) % W == 0) begin
                m_vel = clampv(m_acc + mv);
                m_acc = 0;
                m_vv  = 1'b1;
            end else m_acc = m_acc + mv;
            for (int b = 0; b < 3; b++) begin
                m_fprev[b] = m_filt[b];
                m_hist[b]  = {m_hist[b][F-2:0], m_d2[b]};
                if (m_hist[b] == {F{~m_filt[b]}}) m_filt[b] = ~m_filt[b];
                m_d2[b] = m_d1[b];
                m_d1[b] = raw[b];
            end
            m_hi++;
        end
    end

    always @(negedge clk) begin : compare
        check("cmp_position",   64'(position),   64'(m_pos));
        check("cmp_step",       64'(step),       64'(m_step));
        check("cmp_dir",        64'(dir),        64'(m_dir));
        check("cmp_err",        64'(err),        64'(m_err));
        check("cmp_velocity",   64'(velocity),   64'(m_vel));
        check("cmp_vel_valid",  64'(vel_valid),  64'(m_vv));
        check("cmp_index_seen", 64'(index_seen), 64'(m_iseen));
        check("cmp_index_pos",  64'(index_pos),  64'(m_ipos));
        if (step === 1'b1) step_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic [1:0] v);
        enc_a = v[1];
        enc_b = v[0];
    endtask

    task automatic move(input int d, input int hold);
        g = (g + d + 4) % 4;
        set_ab(gray_tab[g]);
        idle(hold);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        g = 0;
        set_ab(2'b00);
        idle(3);
        rst_n = 1'b1;
        idle(12);
    endtask

    task automatic wait_vel(output int waited);
        waited = 0;
        while (vel_valid !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int s0, lat, r;
        @(negedge clk);
        check("reset_position", 64'(position), 64'd0);
        check("reset_velocity", 64'(velocity), 64'd0);
        check("reset_err",      64'(err),      64'd0);
        do_reset();

        // forward steps, first one timed from the raw edge
        s0 = step_cnt;
        g = (g + 1) % 4;
        set_ab(gray_tab[g]);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (step !== 1'b1 && lat < 20);
        check("step_latency", 64'(lat), 64'd7);
        idle(3);
        repeat (7) move(1, 10);
        idle(10);
        check("fwd_position", 64'(position), 64'd8);
        check("fwd_dir",      64'(dir),      64'd1);
        check("fwd_steps",    64'(step_cnt - s0), 64'd8);

        // reverse from reset wraps below zero
        do_reset();
        repeat (3) move(-1, 10);
        check("rev_position", 64'(position), 64'hFFFF_FFFD);
        check("rev_dir",      64'(dir),      64'd0);

        // pos_clear coincident with a counted step
        g = (g + 1) % 4;
        set_ab(gray_tab[g]);
        idle(6);
        pos_clear = 1'b1;
        @(negedge clk);
        check("clear_step_pulse", 64'(step), 64'd1);
        pos_clear = 1'b0;
        idle(5);
        check("clear_position", 64'(position), 64'd0);

        // illegal double-bit change
        s0 = step_cnt;
        g = (g + 2) % 4;
        set_ab(gray_tab[g]);
        idle(12);
        check("illegal_err",      64'(err), 64'd1);
        check("illegal_no_step",  64'(step_cnt - s0), 64'd0);
        check("illegal_position", 64'(position), 64'd0);

        // short glitch on A is rejected
        enc_a = ~enc_a;
        idle(3);
        enc_a = ~enc_a;
        idle(12);
        check("glitch_position", 64'(position), 64'd0);
        check("glitch_no_step",  64'(step_cnt - s0), 64'd0);

        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        idle(2);
        check("err_cleared", 64'(err), 64'd0);

        // velocity: 20 steps in the first window
        do_reset();
        repeat (20) move(1, 6);
        wait_vel(lat);
        check("vel_valid_seen", 64'(vel_valid), 64'd1);
        check("vel_20",         64'(velocity),  64'd20);
        @(negedge clk);
        check("vel_valid_pulse", 64'(vel_valid), 64'd0);
        repeat (45) move(1, 5);
        wait_vel(lat);
        check("vel_valid_seen2", 64'(vel_valid), 64'd1);
        check("vel_sat_pos",     64'(velocity),  64'd31);
        @(negedge clk);
        repeat (45) move(-1, 5);
        wait_vel(lat);
        check("vel_valid_seen3", 64'(vel_valid), 64'd1);
        check("vel_sat_neg",     64'(velocity),  64'h21);
        @(negedge clk);

`ifdef QUAD_INDEX_EN
        do_reset();
        repeat (57) move(1, 5);
        idle(10);
        index_clr_en = 1'b1;
        enc_i = 1'b1;
        idle(10);
        check("idx_pos_57",      64'(index_pos),  64'd57);
        check("idx_clr_position", 64'(position),  64'd0);
        check("idx_seen",        64'(index_seen), 64'd1);
        enc_i = 1'b0;
        idle(10);
        repeat (5) move(1, 5);
        idle(10);
        index_clr_en = 1'b0;
        enc_i = 1'b1;
        idle(10);
        check("idx_noclr_position", 64'(position),  64'd5);
        check("idx_noclr_pos",      64'(index_pos), 64'd5);
        enc_i = 1'b0;
        idle(10);
`else
        index_clr_en = 1'b1;
        enc_i = 1'b1;
        idle(12);
        check("idx_off_seen",     64'(index_seen), 64'd0);
        check("idx_off_pos",      64'(index_pos),  64'd0);
        check("idx_off_position", 64'(position),   64'd20);
        enc_i = 1'b0;
        index_clr_en = 1'b0;
        idle(5);
`endif

        // reset mid-motion, then come out of reset with the encoder at 11
        repeat (3) move(1, 3);
        rst_n = 1'b0;
        set_ab(2'b11);
        g = 2;
        @(negedge clk);
        check("midrst_position", 64'(position), 64'd0);
        check("midrst_dir",      64'(dir),      64'd0);
        check("midrst_velocity", 64'(velocity), 64'd0);
        check("midrst_err",      64'(err),      64'd0);
        idle(2);
        rst_n = 1'b1;
        s0 = step_cnt;
        idle(20);
        check("start11_err",      64'(err), 64'd0);
        check("start11_no_step",  64'(step_cnt - s0), 64'd0);
        check("start11_position", 64'(position), 64'd0);

        // random motion, glitches, faults, clears and occasional resets
        for (int it = 0; it < 700; it++) begin
            r = $urandom_range(0, 99);
            if (r < 40) move(1, $urandom_range(1, 10));
            else if (r < 72) move(-1, $urandom_range(1, 10));
            else if (r < 77) move(2, $urandom_range(3, 10));
            else if (r < 84) begin
                enc_i = ~enc_i;
                index_clr_en = 1'($urandom_range(0, 1));
                idle($urandom_range(1, 8));
            end else if (r < 90) begin
                pos_clear = 1'b1;
                @(negedge clk);
                pos_clear = 1'b0;
                idle($urandom_range(0, 4));
            end else if (r < 95) begin
                err_clear = 1'b1;
                @(negedge clk);
                err_clear = 1'b0;
                idle($urandom_range(0, 4));
            end else if (r < 99) begin
                enc_b = ~enc_b;
                idle($urandom_range(1, F));
                enc_b = ~enc_b;
                idle($urandom_range(1, 6));
            end else begin
                rst_n = 1'b0;
                idle($urandom_range(1, 3));
                rst_n = 1'b1;
                idle(1);
            end
        end
        idle(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_encoder_decoder.md
# quad_encoder_decoder

Decodes the quadrature feedback (A/B, optional index) of one brushed DC motor into a signed position count and a windowed velocity estimate. It is the feedback-side companion of the PWM/H-bridge motor channel, and one instance sits per motor channel in the MachXO2 fabric. Raw encoder pins enter asynchronously and are synchronized, glitch-filtered and x4-decoded. Illegal transitions are flagged, never counted.

## Interface
- POS_WIDTH, 32: position counter width, two's complement.
- VEL_WIDTH, 16: velocity output width, two's complement.
- FILTER_LEN, 4: consecutive stable samples required before a filtered input changes, >=1.
- VEL_WINDOW, 50000: clk cycles per velocity sample, >=2.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- enc_a, enc_b  in  1 each  raw quadrature pins, asynchronous.
- enc_i  in  1  raw index pin, asynchronous.
- index_clr_en  in  1  allows the index edge to zero the position.
- pos_clear  in  1  one-cycle pulse that zeroes the position.
- err_clear  in  1  clears err.
- position  out  POS_WIDTH  signed count.
- step  out  1  one-cycle pulse per counted edge.
- dir  out  1  direction of the last counted edge: 1 = forward, 0 = reverse.
- velocity  out  VEL_WIDTH  signed counts per window.
- vel_valid  out  1  one-cycle pulse when velocity updates.
- err  out  1  sticky illegal-transition flag.
- index_seen  out  1  sticky flag for an index rising edge.
- index_pos  out  POS_WIDTH  position captured at the index edge.

## Operation
- Reset values: all outputs are 0. Sync flops, filters, accumulator, window counter and the armed flag are all 0.
- Synchronizer: a 2-FF synchronizer on each raw input.
- Filter: the filtered bit takes the synced value after the synced value has differed from it for FILTER_LEN consecutive cycles. Any agreement resets the filter counter.
- Arming: after rst_n rises, `armed` goes high FILTER_LEN+3 cycles later. While unarmed, the previous {A,B} register tracks the filtered {A,B}, and there is no step, no err and no index action.
- Decode of the previous {A,B} against the current {A,B}:
  - Forward sequence: 00→01→11→10→00. Each such transition gives +1, step=1, dir=1.
  - Reverse sequence: the same in the opposite order. Each such transition gives −1, step=1, dir=0.
  - No change: no action.
  - Both bits change: err is set; position, step and dir are unchanged.
- Position wraps modulo 2^POS_WIDTH with no saturation.
- Position priority, highest first:
  - pos_clear sets position to 0, discarding a same-cycle step. It also clears index_seen.
  - An index clear sets position to 0.
  - Otherwise position becomes position ± step.
- err_clear clears err. If an illegal transition occurs in the same cycle, err stays 1.
- Velocity:
  - The window counter runs 0..VEL_WINDOW−1 and wraps.
  - The accumulator adds ±1 per step.
  - On the terminal count, velocity takes (accumulator + this cycle's step), saturated to ±(2^(VEL_WIDTH−1)−1) with −2^(VEL_WIDTH−1) excluded. At the same time the accumulator restarts at 0 and vel_valid=1.
  - pos_clear does not affect velocity.
- Reset mid-operation: everything returns to reset values on the next edge with rst_n=0. Arming restarts after rst_n rises.

## Timing
- Edge latency: a raw edge is first captured at clk edge n. The filtered bit changes at n+1+FILTER_LEN, and step/position/dir/err update at n+2+FILTER_LEN.
- Minimum resolvable edge spacing: FILTER_LEN+1 cycles between A/B changes. Pulses shorter than FILTER_LEN cycles are rejected.
- vel_valid: one pulse every VEL_WINDOW cycles. The first pulse comes VEL_WINDOW cycles after rst_n rises.
- All outputs are registered.

## Configuration
- Macro: QUAD_INDEX_EN.
- Defined: enc_i is synchronized and filtered the same way as A/B. On a filtered index rising edge while armed:
  - index_seen is set.
  - index_pos captures the post-step position value.
  - If index_clr_en=1, position is set to 0.
- Not defined: enc_i and index_clr_en are ignored. index_seen and index_pos are tied to 0. The port list is unchanged.

## Structure
- Package quad_pkg holds:
  - the decode direction encoding (DIR_FWD=1, DIR_REV=0);
  - the forward Gray sequence constants;
  - the saturation helper function.
- Sub-module quad_input_filter (parameter FILTER_LEN) is instantiated per input bit and contains the 2-FF synchronizer plus the stability counter.

## Test plan
- Forward steps: 8 forward quadrature steps spaced 10 cycles apart, FILTER_LEN=4 → position=8, eight step pulses, dir=1, each step 6 cycles after its raw edge.
- Reverse and wrap: 3 reverse steps from reset → position=32'hFFFFFFFD, dir=0. pos_clear in the same cycle as a step → position=0.
- Illegal and glitch input: {A,B} 00→11 → err=1, no step. A 3-cycle glitch on A → no change. err_clear with no new fault → err=0.
- Velocity: VEL_WINDOW=100, 20 forward steps in one window → velocity=20 with a one-cycle vel_valid. Force 40000 steps in one window with VEL_WIDTH=16 → velocity=32767.
- Index (QUAD_INDEX_EN): index_clr_en=1, index rising edge at position 57 → index_pos=57, position=0, index_seen=1. With index_clr_en=0 → position is unchanged.
- Reset mid-motion: assert rst_n=0 mid-sequence → all outputs 0 the next cycle. Start with encoder at 11 after reset → no err and no step.
